// File: rtl/sa_job_ctrl_if.sv
// Bundle between the operand fetch logic, the job controller and the systolic array.
//   start/k_len/busy      : job request and status
//   in_valid/in_ready/... : one reduction step per beat (X vector + ternary W vector)
//   arr_rst/arr_x/arr_w   : controller -> array drive
//   arr_y                 : array -> controller psum matrix
//   out_valid/out_ready/out_y : captured result buffer handshake
// arr_y and out_y share one packing: entry (row i, column j) sits at
// bit offset (i*CONTEXT_LENGTH + j) * 2*WIDTH.
interface sa_job_ctrl_if #(
    parameter int WIDTH          = 16,
    parameter int HIDDEN_SIZE    = 4,
    parameter int CONTEXT_LENGTH = 4,
    parameter int K_W            = 16
);
    logic                                       start;
    logic [K_W-1:0]                             k_len;
    logic                                       busy;
    logic                                       in_valid;
    logic                                       in_ready;
    logic [CONTEXT_LENGTH*WIDTH-1:0]            in_x;
    logic [HIDDEN_SIZE*2-1:0]                   in_w;
    logic                                       arr_rst;
    logic [CONTEXT_LENGTH*WIDTH-1:0]            arr_x;
    logic [HIDDEN_SIZE*2-1:0]                   arr_w;
    logic [HIDDEN_SIZE*CONTEXT_LENGTH*2*WIDTH-1:0] arr_y;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [HIDDEN_SIZE*CONTEXT_LENGTH*2*WIDTH-1:0] out_y;

    // Environment side: fetch logic, array and result consumer.
    modport master (
        output start, k_len, in_valid, in_x, in_w, arr_y, out_ready,
        input  busy, in_ready, arr_rst, arr_x, arr_w, out_valid, out_y
    );

    // Controller side.
    modport slave (
        input  start, k_len, in_valid, in_x, in_w, arr_y, out_ready,
        output busy, in_ready, arr_rst, arr_x, arr_w, out_valid, out_y
    );
endinterface

// File: rtl/sa_job_ctrl.sv
// Job sequencer for the ternary-weight systolic array.
// Accepts k_len reduction steps, skews X lane j by j+1 cycles and W lane i by
// i+1 cycles, turns source stalls into all-zero steps, clears the array at job
// start, waits HIDDEN_SIZE+CONTEXT_LENGTH cycles for the wavefront to drain and
// then captures the psum matrix into a result buffer.
// Ports: clock, rst (synchronous, active-high), bus (sa_job_ctrl_if.slave).
module sa_job_ctrl #(
    parameter int WIDTH          = 16,
    parameter int HIDDEN_SIZE    = 4,
    parameter int CONTEXT_LENGTH = 4,
    parameter int K_W            = 16
) (
    input  logic          clock,
    input  logic          rst,
    sa_job_ctrl_if.slave  bus
);
    localparam int PW     = 2 * WIDTH;
    localparam int YW     = HIDDEN_SIZE * CONTEXT_LENGTH * PW;
    localparam int NDRAIN = HIDDEN_SIZE + CONTEXT_LENGTH;
    localparam int DW     = $clog2(NDRAIN + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(NDRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [K_W-1:0]                  r_klen;
    logic [K_W-1:0]                  r_step;
    logic [K_W-1:0]                  w_step_inc;
    logic [DW-1:0]                   r_drain;
    logic [YW-1:0]                   r_out_y;
    logic                            w_accept;
    logic                            w_last_beat;
    logic                            w_drain_last;
    logic                            w_clear;
    logic                            w_busy;
    logic                            w_in_ready;
    logic                            w_out_valid;
    logic [CONTEXT_LENGTH*WIDTH-1:0] w_x0;
    logic [CONTEXT_LENGTH*WIDTH-1:0] w_arr_x;
    logic [HIDDEN_SIZE*2-1:0]        w_w0;
    logic [HIDDEN_SIZE*2-1:0]        w_arr_w;

    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_step_inc   = r_step + K_W'(1);
    assign w_last_beat  = w_accept & (w_step_inc == r_klen);
    assign w_drain_last = (r_drain == DRAIN_LAST);

    // A cycle without an accepted beat enters the skew as a zero step.
    assign w_x0 = w_accept ? bus.in_x : '0;
    assign w_w0 = w_accept ? bus.in_w : '0;

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)         w_next = S_CLEAR; else w_next = S_IDLE;
            S_CLEAR: if (r_klen != '0)      w_next = S_FEED;  else w_next = S_DRAIN;
            S_FEED:  if (w_last_beat)       w_next = S_DRAIN; else w_next = S_FEED;
            S_DRAIN: if (w_drain_last)      w_next = S_DONE;  else w_next = S_DRAIN;
            S_DONE:  if (bus.out_ready)     w_next = S_IDLE;  else w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        w_busy      = 1'b1;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE:  w_busy      = 1'b0;
            S_CLEAR: w_clear     = 1'b1;
            S_FEED:  w_in_ready  = 1'b1;
            S_DRAIN: w_busy      = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: w_busy      = 1'b0;
        endcase
    end

    // Job bookkeeping: latched length, step and drain counters, result buffer.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_klen  <= '0;
            r_step  <= '0;
            r_drain <= '0;
            r_out_y <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) r_klen <= bus.k_len;
            else                                r_klen <= r_klen;

            if (w_clear)       r_step <= '0;
            else if (w_accept) r_step <= w_step_inc;
            else               r_step <= r_step;

            if (r_state == S_DRAIN) r_drain <= r_drain + DW'(1);
            else                    r_drain <= '0;

            // The last drain cycle is the first one in which the far corner
            // PE has absorbed the final step.
            if (r_state == S_DRAIN && w_drain_last) r_out_y <= bus.arr_y;
            else                                    r_out_y <= r_out_y;
        end
    end

    // X skew: lane j is a (j+1)-deep shift chain; the oldest element drives the array.
    for (genvar j = 0; j < CONTEXT_LENGTH; j++) begin : g_x_lane
        logic [(j+1)*WIDTH-1:0] r_sh;
        if (j == 0) begin : g_first
            // Single-stage lane.
            always_ff @(posedge clock) begin
                if (rst || w_clear) r_sh <= '0;
                else                r_sh <= w_x0[WIDTH-1:0];
            end
        end else begin : g_chain
            // Multi-stage lane, new step enters at the bottom.
            always_ff @(posedge clock) begin
                if (rst || w_clear) r_sh <= '0;
                else                r_sh <= {r_sh[j*WIDTH-1:0], w_x0[j*WIDTH +: WIDTH]};
            end
        end
        assign w_arr_x[j*WIDTH +: WIDTH] = r_sh[(j+1)*WIDTH-1 -: WIDTH];
    end

    // W skew: lane i is an (i+1)-deep shift chain of 2-bit codes, passed through unaltered.
    for (genvar i = 0; i < HIDDEN_SIZE; i++) begin : g_w_lane
        logic [(i+1)*2-1:0] r_sh;
        if (i == 0) begin : g_first
            // Single-stage lane.
            always_ff @(posedge clock) begin
                if (rst || w_clear) r_sh <= '0;
                else                r_sh <= w_w0[1:0];
            end
        end else begin : g_chain
            // Multi-stage lane, new step enters at the bottom.
            always_ff @(posedge clock) begin
                if (rst || w_clear) r_sh <= '0;
                else                r_sh <= {r_sh[i*2-1:0], w_w0[i*2 +: 2]};
            end
        end
        assign w_arr_w[i*2 +: 2] = r_sh[(i+1)*2-1 -: 2];
    end

    assign bus.busy      = w_busy;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.arr_rst   = rst | w_clear;
    assign bus.arr_x     = w_arr_x;
    assign bus.arr_w     = w_arr_w;
    assign bus.out_y     = r_out_y;
endmodule

// File: tb/tb_sa_job_ctrl.sv
// Directed self-checking bench for sa_job_ctrl. Contains a behavioural
// output-stationary ternary systolic array (X flows down columns, W flows
// along rows, one register per PE) that closes the loop through arr_x/arr_w/arr_y.
module tb_sa_job_ctrl;
    localparam int WIDTH = 16;
    localparam int H     = 4;
    localparam int C     = 4;
    localparam int KW    = 16;
    localparam int PW    = 2 * WIDTH;

    logic clock;
    logic rst;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   ready_cnt = 0;
    int   acc_cnt   = 0;
    int   arst_cnt  = 0;

    sa_job_ctrl_if #(.WIDTH(WIDTH), .HIDDEN_SIZE(H), .CONTEXT_LENGTH(C), .K_W(KW)) bus ();

    sa_job_ctrl #(.WIDTH(WIDTH), .HIDDEN_SIZE(H), .CONTEXT_LENGTH(C), .K_W(KW)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- array model ----------------
    logic signed [PW-1:0] m_ps [H][C];
    logic [WIDTH-1:0]     m_x  [H][C];
    logic [1:0]           m_w  [H][C];

    function automatic logic [WIDTH-1:0] xin_of(input int i, input int j);
        if (i == 0) return bus.arr_x[j*WIDTH +: WIDTH];
        else        return m_x[i-1][j];
    endfunction

    function automatic logic [1:0] win_of(input int i, input int j);
        if (j == 0) return bus.arr_w[i*2 +: 2];
        else        return m_w[i][j-1];
    endfunction

    function automatic logic [PW-1:0] prod(input logic [1:0] w, input logic [WIDTH-1:0] x);
        logic [PW-1:0] xe;
        xe = {{WIDTH{x[WIDTH-1]}}, x};
        case (w)
            2'b01:   return xe;
            2'b11:   return -xe;
            default: return '0;
        endcase
    endfunction

    // PE grid: accumulate and forward operands each cycle, cleared by arr_rst.
    always @(posedge clock) begin
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < C; j++) begin
                if (bus.arr_rst) begin
                    m_ps[i][j] <= '0;
                    m_x[i][j]  <= '0;
                    m_w[i][j]  <= '0;
                end else begin
                    m_ps[i][j] <= m_ps[i][j] + prod(win_of(i, j), xin_of(i, j));
                    m_x[i][j]  <= xin_of(i, j);
                    m_w[i][j]  <= win_of(i, j);
                end
            end
        end
    end

    for (genvar gi = 0; gi < H; gi++) begin : g_yr
        for (genvar gj = 0; gj < C; gj++) begin : g_yc
            assign bus.arr_y[(gi*C+gj)*PW +: PW] = m_ps[gi][gj];
        end
    end

    // Cycle index and event counters.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.in_ready)                 ready_cnt <= ready_cnt + 1;
        if (bus.in_valid && bus.in_ready) acc_cnt   <= acc_cnt + 1;
        if (bus.arr_rst && !rst)          arst_cnt  <= arst_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [C*WIDTH-1:0] pack_x(input int v[C]);
        logic [C*WIDTH-1:0] r;
        for (int j = 0; j < C; j++) r[j*WIDTH +: WIDTH] = v[j][WIDTH-1:0];
        return r;
    endfunction

    function automatic logic [H*2-1:0] pack_w(input int v[H]);
        logic [H*2-1:0] r;
        for (int i = 0; i < H; i++) begin
            case (v[i])
                1:       r[i*2 +: 2] = 2'b01;
                -1:      r[i*2 +: 2] = 2'b11;
                default: r[i*2 +: 2] = 2'b00;
            endcase
        end
        return r;
    endfunction

    task automatic start_job(input logic [KW-1:0] k, output int s_cyc);
        bus.k_len = k;
        bus.start = 1'b1;
        s_cyc     = cyc;
        tick();
        bus.start = 1'b0;
        bus.k_len = '0;
    endtask

    task automatic send_beat(input logic [C*WIDTH-1:0] x, input logic [H*2-1:0] w, output int a_cyc);
        int n;
        n            = 0;
        a_cyc        = -1;
        bus.in_x     = x;
        bus.in_w     = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check_value("beat_ready", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) begin
            a_cyc = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d_cyc);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        check_value("done_reached", 64'(bus.out_valid), 64'd1);
        d_cyc = cyc;
    endtask

    task automatic check_entries(input string tag, input int wv[H], input int xv[C], input int k);
        logic [PW-1:0] e;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < C; j++) begin
                e = PW'(wv[i] * xv[j] * k);
                check_value($sformatf("%s_y%0d%0d", tag, i, j),
                            64'(bus.out_y[(i*C+j)*PW +: PW]), 64'(e));
            end
        end
    endtask

    task automatic finish_job();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int xv[C];
        int wv[H];
        int s, a, d, lat2, lat3, r0, ac0, rc0;

        bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
        bus.in_x = '0; bus.in_w = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        check_value("rst_busy",      64'(bus.busy),      64'd0);
        check_value("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check_value("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_value("rst_out_y_nz",  64'(|bus.out_y),    64'd0);
        check_value("rst_arr_x",     64'(bus.arr_x),     64'd0);
        check_value("rst_arr_w",     64'(bus.arr_w),     64'd0);
        check_value("rst_arr_rst",   64'(bus.arr_rst),   64'd1);
        rst = 1'b0;
        tick();
        check_value("idle_arr_rst",  64'(bus.arr_rst),   64'd0);

        // 1: single step, mixed weights, latency
        xv = '{1, 2, 3, 4};
        wv = '{1, -1, 0, 1};
        start_job(16'd1, s);
        check_value("s1_clear_arr_rst", 64'(bus.arr_rst), 64'd1);
        check_value("s1_busy",          64'(bus.busy),    64'd1);
        send_beat(pack_x(xv), pack_w(wv), a);
        wait_done(40, d);
        check_value("s1_latency", 64'(d - a), 64'd9);
        check_entries("s1", wv, xv, 1);
        // start coinciding with leaving DONE must not launch a job
        bus.out_ready = 1'b1; bus.start = 1'b1; bus.k_len = 16'd5;
        tick();
        bus.out_ready = 1'b0; bus.start = 1'b0; bus.k_len = '0;
        check_value("s1_exit_valid", 64'(bus.out_valid), 64'd0);
        check_value("s1_exit_busy",  64'(bus.busy),      64'd0);
        tick();
        check_value("s1_still_idle", 64'(bus.busy),      64'd0);

        // 2: three back-to-back steps
        xv = '{5, 5, 5, 5};
        wv = '{1, 1, 1, 1};
        r0 = ready_cnt;
        start_job(16'd3, s);
        repeat (3) send_beat(pack_x(xv), pack_w(wv), a);
        wait_done(40, d);
        lat2 = d - s;
        check_value("s2_latency",   64'(lat2),            64'd13);
        check_value("s2_ready_cyc", 64'(ready_cnt - r0),  64'd3);
        check_entries("s2", wv, xv, 3);
        finish_job();

        // 3: same job with a two-cycle source stall before the last step
        start_job(16'd3, s);
        repeat (2) send_beat(pack_x(xv), pack_w(wv), a);
        repeat (2) tick();
        send_beat(pack_x(xv), pack_w(wv), a);
        wait_done(40, d);
        lat3 = d - s;
        check_value("s3_delay", 64'(lat3 - lat2), 64'd2);
        check_entries("s3", wv, xv, 3);
        finish_job();

        // 4: empty job with in_valid held high, then a back-to-back job
        rc0 = arst_cnt;
        ac0 = acc_cnt;
        bus.in_x = pack_x('{9, 9, 9, 9}); bus.in_w = pack_w('{1, 1, 1, 1});
        bus.in_valid = 1'b1;
        start_job(16'd0, s);
        wait_done(40, d);
        bus.in_valid = 1'b0;
        check_value("s4_latency",   64'(d - (s + 1)),     64'd9);
        check_value("s4_arr_rst_n", 64'(arst_cnt - rc0),  64'd1);
        check_value("s4_accepts",   64'(acc_cnt - ac0),   64'd0);
        check_entries("s4", wv, xv, 0);
        finish_job();
        xv = '{7, -3, 2, 1};
        wv = '{-1, 1, 1, 0};
        start_job(16'd1, s);
        send_beat(pack_x(xv), pack_w(wv), a);
        wait_done(40, d);
        check_entries("s4b", wv, xv, 1);
        finish_job();

        // 5: sign and width of psums
        xv = '{32767, 32767, 32767, 32767};
        wv = '{1, 1, 1, 1};
        start_job(16'd2, s);
        repeat (2) send_beat(pack_x(xv), pack_w(wv), a);
        wait_done(40, d);
        check_entries("s5p", wv, xv, 2);
        finish_job();
        xv = '{-32768, -32768, -32768, -32768};
        wv = '{-1, -1, -1, -1};
        start_job(16'd2, s);
        repeat (2) send_beat(pack_x(xv), pack_w(wv), a);
        wait_done(40, d);
        check_value("s5n_y00", 64'(bus.out_y[0 +: PW]),           64'd65536);
        check_value("s5n_y33", 64'(bus.out_y[(H*C-1)*PW +: PW]),  64'd65536);
        finish_job();

        // 6: abort mid-FEED, then a normal job held in DONE
        xv = '{3, 3, 3, 3};
        wv = '{1, 1, 1, 1};
        start_job(16'd4, s);
        repeat (2) send_beat(pack_x(xv), pack_w(wv), a);
        rst = 1'b1;
        tick();
        check_value("s6_busy",      64'(bus.busy),      64'd0);
        check_value("s6_in_ready",  64'(bus.in_ready),  64'd0);
        check_value("s6_out_valid", 64'(bus.out_valid), 64'd0);
        check_value("s6_arr_x",     64'(bus.arr_x),     64'd0);
        check_value("s6_arr_w",     64'(bus.arr_w),     64'd0);
        check_value("s6_out_y_nz",  64'(|bus.out_y),    64'd0);
        rst = 1'b0;
        tick();
        check_value("s6_no_valid",  64'(bus.out_valid), 64'd0);
        xv = '{2, 2, 2, 2};
        start_job(16'd1, s);
        send_beat(pack_x(xv), pack_w(wv), a);
        wait_done(40, d);
        check_entries("s6", wv, xv, 1);
        bus.start = 1'b1; bus.k_len = 16'd3;
        for (int n = 0; n < 10; n++) begin
            tick();
            check_value("s6_hold_valid", 64'(bus.out_valid),                  64'd1);
            check_value("s6_hold_y00",   64'(bus.out_y[0 +: PW]),             64'd2);
            check_value("s6_hold_y33",   64'(bus.out_y[(H*C-1)*PW +: PW]),    64'd2);
        end
        bus.start = 1'b0; bus.k_len = '0;
        finish_job();
        check_value("s6_released", 64'(bus.out_valid), 64'd0);
        check_value("s6_idle",     64'(bus.busy),      64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
